// File: rtl/seq_timer_pkg.sv
// Shared types and defaults for the serial-programmed timer controller.
package seq_timer_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SHIFT  = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  localparam int         DEF_PATTERN_W   = 4;
  localparam logic [3:0] DEF_PATTERN     = 4'b1101;
  localparam int         DEF_DELAY_W     = 4;
  localparam int         DEF_UNIT_CYCLES = 1000;

  // max(1, $clog2(unit_cycles)) so a one-cycle unit still gets a real flop
  function automatic int presc_width(input int unit_cycles);
    return (unit_cycles <= 2) ? 1 : $clog2(unit_cycles);
  endfunction

endpackage

// File: rtl/seq_timer_prescaler.sv
// Modulo-UNIT_CYCLES counter; tick marks the last cycle of each delay unit.
module seq_timer_prescaler
  import seq_timer_pkg::*;
#(
  parameter int UNIT_CYCLES = DEF_UNIT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            PW   = presc_width(UNIT_CYCLES);
  localparam logic [PW-1:0] LAST = PW'(UNIT_CYCLES - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seq_timer_fsm.sv
// Pattern-triggered serial-programmed countdown timer.
// Optional `abort` input enabled by defining SEQ_TIMER_ABORT_EN.
module seq_timer_fsm
  import seq_timer_pkg::*;
#(
  parameter int                   PATTERN_W   = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN     = PATTERN_W'(DEF_PATTERN),
  parameter int                   DELAY_W     = DEF_DELAY_W,
  parameter int                   UNIT_CYCLES = DEF_UNIT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               ack,
`ifdef SEQ_TIMER_ABORT_EN
  input  logic               abort,
`endif
  output logic               shift_ena,
  output logic               counting,
  output logic               done,
  output logic [DELAY_W-1:0] count
);

  localparam int                FILL_W    = $clog2(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W - 1);
  localparam int                SCNT_W    = $clog2(DELAY_W + 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(DELAY_W - 1);

  seq_state_t           state_q, state_d;
  logic [PATTERN_W-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [SCNT_W-1:0]    scnt_q, scnt_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic                 match, tick, abort_fire;

`ifdef SEQ_TIMER_ABORT_EN
  assign abort_fire = abort && (state_q != SEARCH);
`else
  assign abort_fire = 1'b0;
`endif

  assign match = (state_q == SEARCH) && (fill_q == FILL_FULL) &&
                 ({hist_q, data} == PATTERN);

  // hist/fill/scnt default to zero so any return to SEARCH starts fresh
  always_comb begin
    state_d = state_q;
    hist_d  = '0;
    fill_d  = '0;
    scnt_d  = '0;
    delay_d = delay_q;
    unique case (state_q)
      SEARCH: begin
        hist_d = (PATTERN_W-1)'({hist_q, data});
        fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        if (match) state_d = SHIFT;
      end
      SHIFT: begin
        delay_d = DELAY_W'({delay_q, data});
        scnt_d  = scnt_q + 1'b1;
        if (scnt_q == SCNT_LAST) state_d = COUNT;
      end
      COUNT: begin
        if (tick) begin
          if (delay_q != '0) delay_d = delay_q - 1'b1;
          else               state_d = DONE;
        end
      end
      DONE: begin
        if (ack) state_d = SEARCH;
      end
    endcase
    if (abort_fire) begin
      state_d = SEARCH;
      delay_d = delay_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
      hist_q  <= '0;
      fill_q  <= '0;
      scnt_q  <= '0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      scnt_q  <= scnt_d;
      delay_q <= delay_d;
    end
  end

  // Prescaler is held clear outside COUNT, so every COUNT entry starts at zero
  seq_timer_prescaler #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_presc (
    .clk  (clk),
    .reset(reset),
    .clr  ((state_q != COUNT) || abort_fire),
    .en   (state_q == COUNT),
    .tick (tick)
  );

  assign shift_ena = (state_q == SHIFT);
  assign counting  = (state_q == COUNT);
  assign done      = (state_q == DONE);
  assign count     = delay_q;

endmodule
